// File: rtl/host_spi_master_if.sv
// rtl/host_spi_master_if.sv - host-side command, word stream and SPI pin bundle for host_spi_master
interface host_spi_master_if;
  logic        start;
  logic [1:0]  mode;
  logic [9:0]  nwords;
  logic        abort_busy;
  logic        tx_rd;
  logic [15:0] tx_data;
  logic        rx_wr;
  logic [15:0] rx_data;
  logic [15:0] status;
  logic        busy;
  logic        done;
  logic        spi_sclk;
  logic [1:0]  spi_cs;
  logic        spi_mosi;
  logic        spi_miso;

  modport master (
    input  start, mode, nwords, abort_busy, tx_data, spi_miso,
    output tx_rd, rx_wr, rx_data, status, busy, done, spi_sclk, spi_cs, spi_mosi
  );

  modport slave (
    output start, mode, nwords, abort_busy, tx_data, spi_miso,
    input  tx_rd, rx_wr, rx_data, status, busy, done, spi_sclk, spi_cs, spi_mosi
  );
endinterface

// File: rtl/host_spi_master.sv
// rtl/host_spi_master.sv - mode-0 SPI master moving nwords 16-bit words per chip-select window
module host_spi_master #(
  parameter int DIV    = 2,
  parameter int CS_GAP = 4
) (
  input  logic               hb_clk,
  input  logic               hb_rst_n,
  host_spi_master_if.master  bus
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, WEND, GAP} state_t;

  state_t      state, state_d;
  logic [DW-1:0] div_cnt, div_cnt_d;
  logic [GW-1:0] gap_cnt, gap_cnt_d;
  logic [3:0]  bit_cnt, bit_cnt_d;
  logic [9:0]  word_cnt, word_cnt_d;
  logic [1:0]  mode_l, mode_d;
  logic        abort_l, abort_d;
  logic        first_word, first_d;
  logic        last_word, last_d;
  logic [15:0] tx_sh, tx_sh_d;
  logic [15:0] rx_sh, rx_sh_d;
  logic        sclk_q, sclk_d;
  logic [1:0]  cs_q, cs_d;
  logic        mosi_q, mosi_d;
  logic        tx_rd_q, tx_rd_d;
  logic        rx_wr_q, rx_wr_d;
  logic [15:0] rx_data_q, rx_data_d;
  logic [15:0] status_q, status_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cont;

  // A host transaction is cut short after word 0 when the slave flags not-ready.
  assign cont = (word_cnt != 10'd1) &&
                !(first_word && abort_l && (mode_l == 2'b01) && rx_sh[13]);

  always_comb begin
    state_d    = state;
    div_cnt_d  = div_cnt + DW'(1);
    gap_cnt_d  = gap_cnt;
    bit_cnt_d  = bit_cnt;
    word_cnt_d = word_cnt;
    mode_d     = mode_l;
    abort_d    = abort_l;
    first_d    = first_word;
    last_d     = last_word;
    tx_sh_d    = tx_sh;
    rx_sh_d    = rx_sh;
    sclk_d     = sclk_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    tx_rd_d    = 1'b0;
    rx_wr_d    = 1'b0;
    rx_data_d  = rx_data_q;
    status_d   = status_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && bus.mode[0]) begin
          if (bus.nwords == 10'd0) begin
            done_d = 1'b1;
          end else begin
            state_d    = SETUP;
            div_cnt_d  = '0;
            bit_cnt_d  = '0;
            word_cnt_d = bus.nwords;
            mode_d     = bus.mode;
            abort_d    = bus.abort_busy;
            first_d    = 1'b1;
            last_d     = 1'b0;
            cs_d       = bus.mode;
            tx_rd_d    = 1'b1;
            tx_sh_d    = bus.tx_data;
            mosi_d     = bus.tx_data[15];
            busy_d     = 1'b1;
          end
        end
      end
      SETUP, LOW: begin
        if (div_cnt == DIV_LAST) begin
          state_d   = HIGH;
          div_cnt_d = '0;
          sclk_d    = 1'b1;
          rx_sh_d   = {rx_sh[14:0], bus.spi_miso};
        end
      end
      HIGH: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_d = '0;
          sclk_d    = 1'b0;
          if (bit_cnt == 4'd15) begin
            // WEND doubles as the first low cycle so the next word follows with no SCLK gap.
            state_d    = WEND;
            bit_cnt_d  = '0;
            rx_wr_d    = 1'b1;
            rx_data_d  = rx_sh;
            if (first_word) status_d = rx_sh;
            first_d    = 1'b0;
            word_cnt_d = word_cnt - 10'd1;
            last_d     = !cont;
            if (cont) begin
              tx_rd_d = 1'b1;
              tx_sh_d = bus.tx_data;
              mosi_d  = bus.tx_data[15];
            end else begin
              mosi_d  = 1'b0;
            end
          end else begin
            state_d   = LOW;
            bit_cnt_d = bit_cnt + 4'd1;
            tx_sh_d   = {tx_sh[14:0], 1'b0};
            mosi_d    = tx_sh[14];
          end
        end
      end
      WEND: begin
        if (last_word) begin
          state_d   = GAP;
          cs_d      = 2'b00;
          gap_cnt_d = '0;
          done_d    = (CS_GAP == 1);
        end else if (div_cnt == DIV_LAST) begin
          state_d   = HIGH;
          div_cnt_d = '0;
          sclk_d    = 1'b1;
          rx_sh_d   = {rx_sh[14:0], bus.spi_miso};
        end else begin
          state_d   = LOW;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt + GW'(1);
          done_d    = ((gap_cnt + GW'(1)) == GAP_LAST);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      mode_l     <= 2'b00;
      abort_l    <= 1'b0;
      first_word <= 1'b0;
      last_word  <= 1'b0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      sclk_q     <= 1'b0;
      cs_q       <= 2'b00;
      mosi_q     <= 1'b0;
      tx_rd_q    <= 1'b0;
      rx_wr_q    <= 1'b0;
      rx_data_q  <= '0;
      status_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_d;
      div_cnt    <= div_cnt_d;
      gap_cnt    <= gap_cnt_d;
      bit_cnt    <= bit_cnt_d;
      word_cnt   <= word_cnt_d;
      mode_l     <= mode_d;
      abort_l    <= abort_d;
      first_word <= first_d;
      last_word  <= last_d;
      tx_sh      <= tx_sh_d;
      rx_sh      <= rx_sh_d;
      sclk_q     <= sclk_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      tx_rd_q    <= tx_rd_d;
      rx_wr_q    <= rx_wr_d;
      rx_data_q  <= rx_data_d;
      status_q   <= status_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.spi_sclk = sclk_q;
  assign bus.spi_cs   = cs_q;
  assign bus.spi_mosi = mosi_q;
  assign bus.tx_rd    = tx_rd_q;
  assign bus.rx_wr    = rx_wr_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.status   = status_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_host_spi_master.sv
// tb/tb_host_spi_master.sv - scoreboard bench with a word-level SPI slave and reference model
module tb_host_spi_master;
  localparam int DIV    = 2;
  localparam int CS_GAP = 4;

  typedef struct {
    logic [15:0] status;
    int          rises;
    bit          zero;
  } done_t;

  logic hb_clk = 1'b0;
  logic hb_rst_n = 1'b0;
  always #5 hb_clk = ~hb_clk;

  host_spi_master_if bus();
  host_spi_master_if bus1();

  host_spi_master #(.DIV(DIV), .CS_GAP(CS_GAP)) u_dut (
    .hb_clk(hb_clk), .hb_rst_n(hb_rst_n), .bus(bus.master));
  host_spi_master #(.DIV(1), .CS_GAP(2)) u_dut1 (
    .hb_clk(hb_clk), .hb_rst_n(hb_rst_n), .bus(bus1.master));

  int checks = 0;
  int failures = 0;

  logic [15:0] tx_q[$];
  logic [15:0] sl_q[$];
  logic [15:0] exp_rx[$];
  logic [15:0] exp_mosi[$];
  done_t       exp_done[$];
  logic [1:0]  exp_mode;
  logic [15:0] model_status = 16'h0000;

  int done_cnt = 0, tx_rd_cnt = 0, rx_wr_cnt = 0, rises = 0;
  int since = 0, gap = 0, asm_n = 0, sl_bit = 0;
  bit first_rise = 1'b0, sl_active = 1'b0;
  logic prev_sclk = 1'b0;
  logic [1:0] prev_cs = 2'b00;
  logic [15:0] asm_w = '0, sl_word = '0;

  int rx1 = 0, rx1_bad = 0, tx1 = 0, cs1_rise = 0, done1 = 0;
  logic [1:0] prev_cs1 = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor, word source and mode-0 slave for the DIV=2 instance.
  always @(negedge hb_clk) begin
    if (!hb_rst_n) begin
      asm_n = 0; since = 0; rises = 0; gap = 0; sl_active = 1'b0;
      prev_sclk = 1'b0; prev_cs = 2'b00;
      bus.spi_miso = 1'b0;
      bus.tx_data  = 16'h0000;
    end else begin
      if (bus.tx_rd) begin
        tx_rd_cnt++;
        if (tx_q.size() != 0) void'(tx_q.pop_front());
        else check("tx_underflow", 1, 0);
      end
      if (bus.rx_wr) begin
        rx_wr_cnt++;
        if (exp_rx.size() != 0) check("rx_data", bus.rx_data, exp_rx.pop_front());
        else check("rx_unexpected", 1, 0);
      end
      since++;
      gap++;
      if (bus.spi_cs != 2'b00 && prev_cs == 2'b00) begin
        since = 0;
        first_rise = 1'b1;
        check("cs_code", bus.spi_cs, exp_mode);
      end
      if (bus.spi_cs == 2'b00 && prev_cs != 2'b00) gap = 1;
      if (bus.spi_sclk && !prev_sclk) begin
        check("sclk_spacing", since, first_rise ? DIV : 2 * DIV);
        first_rise = 1'b0;
        since = 0;
        rises++;
        asm_w = {asm_w[14:0], bus.spi_mosi};
        asm_n++;
        if (asm_n == 16) begin
          asm_n = 0;
          if (exp_mosi.size() != 0) check("mosi_word", asm_w, exp_mosi.pop_front());
          else check("mosi_unexpected", 1, 0);
        end
      end
      if (bus.done) begin
        done_t e;
        done_cnt++;
        if (exp_done.size() != 0) begin
          e = exp_done.pop_front();
          check("status", bus.status, e.status);
          check("sclk_rises", rises, e.rises);
          if (!e.zero) check("cs_gap", gap, CS_GAP);
          else check("cs_idle_zero", bus.spi_cs, 2'b00);
        end else begin
          check("done_unexpected", 1, 0);
        end
        rises = 0;
      end
      if (bus.spi_cs == 2'b00) begin
        sl_active = 1'b0;
        bus.spi_miso = 1'b0;
      end else if (!sl_active) begin
        sl_active = 1'b1;
        sl_bit = 0;
        sl_word = (sl_q.size() != 0) ? sl_q.pop_front() : 16'h8000;
        bus.spi_miso = sl_word[15];
      end else if (!bus.spi_sclk && prev_sclk) begin
        sl_bit++;
        if (sl_bit == 16) begin
          sl_bit = 0;
          sl_word = (sl_q.size() != 0) ? sl_q.pop_front() : 16'h0000;
        end
        bus.spi_miso = sl_word[15 - sl_bit];
      end
      prev_sclk = bus.spi_sclk;
      prev_cs = bus.spi_cs;
      bus.tx_data = (tx_q.size() != 0) ? tx_q[0] : 16'h0000;
    end
  end

  always @(negedge hb_clk) begin
    if (hb_rst_n) begin
      if (bus1.rx_wr) begin
        rx1++;
        if (bus1.rx_data != 16'hFFFF) rx1_bad++;
      end
      if (bus1.tx_rd) tx1++;
      if (bus1.spi_cs != 2'b00 && prev_cs1 == 2'b00) cs1_rise++;
      if (bus1.done) done1++;
      prev_cs1 = bus1.spi_cs;
    end
  end

  task automatic issue(input logic [1:0] m, input int n, input logic ab,
                       input logic [15:0] txw[$], input logic [15:0] sw[$], output int neff);
    done_t e;
    neff = n;
    if (n != 0 && ab && m == 2'b01 && sw[0][13]) neff = 1;
    for (int i = 0; i < n; i++) begin
      tx_q.push_back(txw[i]);
      sl_q.push_back(sw[i]);
    end
    for (int i = 0; i < neff; i++) begin
      exp_rx.push_back(sw[i]);
      exp_mosi.push_back(txw[i]);
    end
    if (neff != 0) model_status = sw[0];
    e.status = model_status;
    e.rises  = 16 * neff;
    e.zero   = (n == 0);
    exp_done.push_back(e);
    exp_mode = m;
    @(negedge hb_clk); #1;
    bus.start = 1'b1; bus.mode = m; bus.nwords = 10'(n); bus.abort_busy = ab;
    @(negedge hb_clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_txn(input logic [1:0] m, input int n, input logic ab,
                         input logic [15:0] txw[$], input logic [15:0] sw[$], input bit spurious);
    int neff, snap_d, snap_tx, snap_rx, limit;
    snap_d = done_cnt; snap_tx = tx_rd_cnt; snap_rx = rx_wr_cnt;
    limit = 200 + n * 40 * DIV;
    issue(m, n, ab, txw, sw, neff);
    check("busy_after_start", bus.busy, (n != 0));
    if (n == 0) check("done_next_cycle", done_cnt, snap_d + 1);
    for (int c = 0; c < limit && done_cnt == snap_d; c++) begin
      if (spurious && c == 20) begin
        bus.start = 1'b1; bus.mode = 2'b11; bus.nwords = 10'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge hb_clk); #1;
    end
    bus.start = 1'b0;
    check("done_seen", done_cnt, snap_d + 1);
    check("busy_at_done", bus.busy, (n != 0));
    @(negedge hb_clk); #1;
    check("busy_after_done", bus.busy, 0);
    check("tx_rd_count", tx_rd_cnt - snap_tx, neff);
    check("rx_wr_count", rx_wr_cnt - snap_rx, neff);
    tx_q.delete();
    sl_q.delete();
  endtask

  task automatic rand_words(input int n, output logic [15:0] txw[$], output logic [15:0] sw[$]);
    txw.delete();
    sw.delete();
    for (int i = 0; i < n; i++) begin
      txw.push_back(16'($urandom));
      sw.push_back(16'($urandom) | ((i == 0) ? 16'h8000 : 16'h0000));
    end
  endtask

  initial begin
    logic [15:0] txw[$];
    logic [15:0] sw[$];
    int neff, snap_d;
    bus.start = 1'b0; bus.mode = 2'b00; bus.nwords = '0; bus.abort_busy = 1'b0;
    bus1.start = 1'b0; bus1.mode = 2'b00; bus1.nwords = '0; bus1.abort_busy = 1'b0;
    bus1.tx_data = 16'hC3C3; bus1.spi_miso = 1'b1;
    repeat (3) @(negedge hb_clk);
    check("rst_cs", bus.spi_cs, 2'b00);
    check("rst_sclk", bus.spi_sclk, 0);
    check("rst_mosi", bus.spi_mosi, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_tx_rd", bus.tx_rd, 0);
    check("rst_status", bus.status, 16'h0000);
    check("rst_rx_data", bus.rx_data, 16'h0000);
    hb_rst_n = 1'b1;

    txw = '{16'hA55A, 16'h1234};
    sw  = '{16'h8000, 16'hBEEF};
    run_txn(2'b01, 2, 1'b0, txw, sw, 1'b0);
    check("status_basic", bus.status, 16'h8000);

    txw = '{16'h1111, 16'h2222, 16'h3333};
    sw  = '{16'hA000, 16'h5555, 16'h6666};
    run_txn(2'b01, 3, 1'b1, txw, sw, 1'b0);
    check("status_abort", bus.status, 16'hA000);
    run_txn(2'b01, 3, 1'b0, txw, sw, 1'b0);
    run_txn(2'b11, 2, 1'b1, txw, sw, 1'b0);

    txw.delete(); sw.delete();
    run_txn(2'b01, 0, 1'b0, txw, sw, 1'b0);

    rand_words(2, txw, sw);
    run_txn(2'b11, 2, 1'b0, txw, sw, 1'b1);

    for (int k = 0; k < 2; k++) begin
      snap_d = done_cnt;
      @(negedge hb_clk); #1;
      bus.start = 1'b1; bus.mode = (k == 0) ? 2'b10 : 2'b00; bus.nwords = 10'd3;
      @(negedge hb_clk); #1;
      bus.start = 1'b0;
      repeat (5) @(negedge hb_clk);
      #1;
      check("bad_mode_busy", bus.busy, 0);
      check("bad_mode_cs", bus.spi_cs, 2'b00);
      check("bad_mode_done", done_cnt, snap_d);
    end

    for (int k = 0; k < 10; k++) begin
      int n;
      n = $urandom_range(1, 4);
      rand_words(n, txw, sw);
      run_txn(($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01, n, 1'($urandom_range(0, 1)), txw, sw, 1'b0);
    end

    rand_words(3, txw, sw);
    sw[0] = sw[0] & 16'hDFFF;
    issue(2'b01, 3, 1'b1, txw, sw, neff);
    for (int c = 0; c < 400 && rises < 24; c++) begin
      @(negedge hb_clk); #1;
    end
    check("reached_word1_bit7", rises, 24);
    check("cs_before_reset", bus.spi_cs, 2'b01);
    snap_d = done_cnt;
    hb_rst_n = 1'b0;
    #1;
    check("reset_cs_now", bus.spi_cs, 2'b00);
    check("reset_sclk_now", bus.spi_sclk, 0);
    check("reset_status_now", bus.status, 16'h0000);
    exp_rx.delete(); exp_mosi.delete(); exp_done.delete();
    tx_q.delete(); sl_q.delete();
    model_status = 16'h0000;
    repeat (3) @(negedge hb_clk);
    hb_rst_n = 1'b1;
    repeat (8) @(negedge hb_clk);
    #1;
    check("no_done_after_reset", done_cnt, snap_d);
    rand_words(2, txw, sw);
    run_txn(2'b01, 2, 1'b0, txw, sw, 1'b0);

    @(negedge hb_clk); #1;
    bus1.start = 1'b1; bus1.mode = 2'b11; bus1.nwords = 10'd1023;
    @(negedge hb_clk); #1;
    bus1.start = 1'b0;
    for (int c = 0; c < 40000 && done1 == 0; c++) begin
      @(negedge hb_clk); #1;
    end
    check("long_done", done1, 1);
    check("long_rx_wr", rx1, 1023);
    check("long_tx_rd", tx1, 1023);
    check("long_rx_data_bad", rx1_bad, 0);
    check("long_cs_continuous", cs1_rise, 1);
    check("long_status", bus1.status, 16'hFFFF);

    check("left_rx", exp_rx.size(), 0);
    check("left_mosi", exp_mosi.size(), 0);
    check("left_done", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
